// File: rtl/mult_share_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : mult_share_sched_if
// Brief   : Requester, multiplier-core and response bundle of the
//           shared-multiplier scheduler.
// Revision: 1.0
// ============================================================================
interface mult_share_sched_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_bus;
   logic [NREQ*W-1:0] b_bus;
   logic [NREQ-1:0]   gnt;
   logic              m_st;
   logic [W-1:0]      m_a;
   logic [W-1:0]      m_b;
   logic              m_done;
   logic [2*W-1:0]    m_result;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_id;
   logic [2*W-1:0]    rsp_result;
   logic              rsp_err;
   logic              busy;

   // Scheduler side
   modport slave (
      input  req, a_bus, b_bus, m_done, m_result,
      output gnt, m_st, m_a, m_b, rsp_valid, rsp_id, rsp_result, rsp_err, busy
   );

   // Requesters plus multiplier core side
   modport master (
      output req, a_bus, b_bus, m_done, m_result,
      input  gnt, m_st, m_a, m_b, rsp_valid, rsp_id, rsp_result, rsp_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module  : mult_share_sched
// Brief   : Round-robin scheduler sharing one sequential multiplier core
//           among NREQ requesters, with a done timeout.
// Revision: 1.0
// ============================================================================
module mult_share_sched #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 40
) (
   input  logic                clk,
   input  logic                rst,
   mult_share_sched_if.slave   bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT - 1);
   localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   id_q, id_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [IW-1:0]   rsp_id_q, rsp_id_d;
   logic [2*W-1:0]  rsp_result_q, rsp_result_d;
   logic            rsp_err_q, rsp_err_d;

   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [IW:0]     cand;

   // Search starts at the pointer and wraps modulo NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!win_found && bus.req[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d = S_ISSUE;
               id_d    = win_idx;
               a_d     = bus.a_bus[win_idx*W +: W];
               b_d     = bus.b_bus[win_idx*W +: W];
               ptr_d   = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done strobe on the final counted cycle still beats the timeout.
            if (bus.m_done) begin
               state_d      = S_RESP;
               rsp_id_d     = id_q;
               rsp_result_d = bus.m_result;
               rsp_err_d    = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = S_RESP;
               rsp_id_d     = id_q;
               rsp_result_d = '0;
               rsp_err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         id_q         <= '0;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.gnt        = (state_q == S_ISSUE) ? (GNT_ONE << id_q) : '0;
   assign bus.m_st       = (state_q == S_ISSUE);
   assign bus.m_a        = a_q;
   assign bus.m_b        = b_q;
   assign bus.rsp_valid  = (state_q == S_RESP);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_share_sched
// Brief   : Randomized scoreboard bench for the shared-multiplier scheduler.
// Revision: 1.0
// ============================================================================
module tb_mult_share_sched;
   localparam int NREQ    = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 40;
   localparam int IW      = 2;

   typedef struct {
      int id;
      int result;
      int err;
      int cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;

   int   total = 0;
   int   bad   = 0;

   exp_t       exp_q[$];
   int         gnt_log[$];
   int         prob[NREQ];
   int         shots[NREQ];
   logic       fix_valid[NREQ];
   logic [W-1:0] fix_a[NREQ];
   logic [W-1:0] fix_b[NREQ];
   logic       req_on[NREQ];
   logic [W-1:0] req_a[NREQ];
   logic [W-1:0] req_b[NREQ];
   int         issued[NREQ];
   int         granted[NREQ];
   int         next_lat;
   int         err_seen;
   logic       model_idle;

   mult_share_sched_if #(.NREQ(NREQ), .W(W)) bus ();

   mult_share_sched #(
      .NREQ    (NREQ),
      .W       (W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Requesters: raise on a shot or by probability, hold until granted.
   initial begin : requesters
      logic [NREQ-1:0] g;
      for (int i = 0; i < NREQ; i++) begin
         req_on[i] = 1'b0;
         req_a[i]  = '0;
         req_b[i]  = '0;
      end
      bus.req   = '0;
      bus.a_bus = '0;
      bus.b_bus = '0;
      forever begin
         @(negedge clk);
         g = bus.gnt;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (g[i]) req_on[i] = 1'b0;
            if (!req_on[i] && (shots[i] > 0 || int'($urandom_range(99)) < prob[i])) begin
               if (shots[i] > 0) shots[i]--;
               req_on[i] = 1'b1;
               issued[i]++;
               if (fix_valid[i]) begin
                  req_a[i]     = fix_a[i];
                  req_b[i]     = fix_b[i];
                  fix_valid[i] = 1'b0;
               end else begin
                  req_a[i] = W'($urandom);
                  req_b[i] = W'($urandom);
               end
            end
            bus.req[i]             = req_on[i];
            bus.a_bus[i*W +: W]    = req_a[i];
            bus.b_bus[i*W +: W]    = req_b[i];
         end
      end
   end

   // Multiplier core: done next_lat cycles after start; 0 means never.
   initial begin : core
      int l;
      logic [2*W-1:0] p;
      bus.m_done   = 1'b0;
      bus.m_result = 16'hdead;
      forever begin
         @(negedge clk);
         if (bus.m_st && next_lat != 0) begin
            l = next_lat;
            p = 16'(bus.m_a) * 16'(bus.m_b);
            repeat (l) @(posedge clk);
            #1;
            bus.m_done   = 1'b1;
            bus.m_result = p;
            @(posedge clk);
            #1;
            bus.m_done   = 1'b0;
            bus.m_result = 16'($urandom);
         end
      end
   end

   // Reference model: predicts grants, operand routing and response timing.
   initial begin : model
      logic [NREQ-1:0] req_prev;
      logic rst_prev, idle, started, ok;
      int ptr, exp_r, w, lat;
      logic [W-1:0] cur_a, cur_b;
      logic [NREQ-1:0] exp_gnt;
      logic issue;
      req_prev = '0; rst_prev = 1'b0; idle = 1'b1; started = 1'b0;
      ptr = 0; exp_r = -10; cur_a = '0; cur_b = '0;
      model_idle = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            started = 1'b1; idle = 1'b1; ptr = 0; exp_r = -10;
            cur_a = '0; cur_b = '0;
            exp_q.delete();
            chk("rst_gnt", 32'(bus.gnt), 0);
            chk("rst_m_st", 32'(bus.m_st), 0);
            chk("rst_m_a", 32'(bus.m_a), 0);
            chk("rst_m_b", 32'(bus.m_b), 0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst_rsp_id", 32'(bus.rsp_id), 0);
            chk("rst_rsp_result", 32'(bus.rsp_result), 0);
            chk("rst_rsp_err", 32'(bus.rsp_err), 0);
            chk("rst_busy", 32'(bus.busy), 0);
         end else if (started) begin
            issue = 1'b0;
            exp_gnt = '0;
            if (idle) begin
               if (req_prev != '0) begin
                  w = -1;
                  for (int k = 0; k < NREQ; k++) begin
                     if (w < 0 && req_prev[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
                  end
                  issue = 1'b1;
                  idle = 1'b0;
                  exp_gnt[w] = 1'b1;
                  ptr = (w + 1) % NREQ;
                  cur_a = req_a[w];
                  cur_b = req_b[w];
                  lat = next_lat;
                  ok = (lat >= 1 && lat <= TIMEOUT);
                  exp_r = cyc + (ok ? lat : TIMEOUT) + 1;
                  exp_q.push_back('{w, ok ? int'(cur_a) * int'(cur_b) : 0, ok ? 0 : 1, exp_r});
                  gnt_log.push_back(w);
                  granted[w]++;
               end
            end else if (cyc == exp_r + 1) begin
               idle = 1'b1;
            end
            chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
            chk("m_st", 32'(bus.m_st), 32'(issue));
            chk("busy", 32'(bus.busy), 32'(!idle));
            chk("m_a", 32'(bus.m_a), 32'(cur_a));
            chk("m_b", 32'(bus.m_b), 32'(cur_b));
            if (cyc == exp_r) chk("rsp_valid_due", 32'(bus.rsp_valid), 1);
         end
         model_idle = idle;
         req_prev = bus.req;
         rst_prev = rst;
      end
   end

   // Response monitor: pops the scoreboard whenever the DUT answers.
   initial begin : rsp_mon
      exp_t e;
      logic rst_prev, seen_rst;
      int hid, hres, herr;
      rst_prev = 1'b0; seen_rst = 1'b0; hid = 0; hres = 0; herr = 0;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            seen_rst = 1'b1; hid = 0; hres = 0; herr = 0;
         end
         if (seen_rst) begin
            if (bus.rsp_valid) begin
               if (exp_q.size() == 0) begin
                  chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                  chk("rsp_result", 32'(bus.rsp_result), 32'(e.result));
                  chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                  chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                  hid = e.id; hres = e.result; herr = e.err;
                  if (e.err != 0) err_seen++;
               end
            end else begin
               chk("hold_rsp_id", 32'(bus.rsp_id), 32'(hid));
               chk("hold_rsp_result", 32'(bus.rsp_result), 32'(hres));
               chk("hold_rsp_err", 32'(bus.rsp_err), 32'(herr));
            end
         end
         rst_prev = rst;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic quiet();
      logic q;
      q = model_idle && (exp_q.size() == 0);
      for (int i = 0; i < NREQ; i++) begin
         if (req_on[i] || shots[i] != 0 || prob[i] != 0) q = 1'b0;
      end
      return q;
   endfunction

   task automatic drain(input string name, input int bound);
      int n;
      n = 0;
      while (!quiet() && n < bound) begin
         step(1);
         n++;
      end
      chk(name, 32'(quiet()), 1);
   endtask

   task automatic wait_grants(input string name, input int cnt, input int bound);
      int n;
      n = 0;
      while (gnt_log.size() < cnt && n < bound) begin
         step(1);
         n++;
      end
      chk(name, 32'(gnt_log.size() >= cnt), 1);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      step(n);
      rst = 1'b0;
      step(1);
   endtask

   function automatic int pick_lat();
      int r;
      r = int'($urandom_range(19));
      if (r == 0) return 0;
      if (r == 1) return TIMEOUT;
      return 1 + int'($urandom_range(11));
   endfunction

   initial begin : main
      rst = 1'b1;
      next_lat = 10;
      err_seen = 0;
      for (int i = 0; i < NREQ; i++) begin
         prob[i] = 0; shots[i] = 0; fix_valid[i] = 1'b0;
         fix_a[i] = '0; fix_b[i] = '0; issued[i] = 0; granted[i] = 0;
      end
      step(3);
      rst = 1'b0;
      step(2);

      // Single request: 3 * 5 from requester 1, core latency 10
      gnt_log.delete();
      fix_a[1] = 8'd3; fix_b[1] = 8'd5; fix_valid[1] = 1'b1;
      shots[1] = 1;
      drain("drain_single", 200);
      chk("single_cnt", 32'(gnt_log.size()), 1);
      chk("single_id", 32'(gnt_log[0]), 1);

      // All four requesting at once, re-raising after each grant
      do_reset(2);
      gnt_log.delete();
      fix_a[3] = 8'd255; fix_b[3] = 8'd255; fix_valid[3] = 1'b1;
      next_lat = 3;
      for (int i = 0; i < NREQ; i++) prob[i] = 100;
      wait_grants("wait_rr", 5, 400);
      for (int i = 0; i < NREQ; i++) prob[i] = 0;
      drain("drain_rr", 400);
      for (int k = 0; k < 5; k++) chk("rr_order", 32'(gnt_log[k]), 32'(k % 4));

      // Fairness between two permanently high requesters
      do_reset(2);
      gnt_log.delete();
      next_lat = 2;
      prob[0] = 100; prob[2] = 100;
      wait_grants("wait_fair", 8, 400);
      prob[0] = 0; prob[2] = 0;
      drain("drain_fair", 400);
      for (int k = 0; k < 8; k++) chk("fair_order", 32'(gnt_log[k]), 32'((k % 2) * 2));

      // Timeout, then a normal request
      err_seen = 0;
      next_lat = 0;
      shots[1] = 1;
      drain("drain_timeout", 200);
      chk("timeout_err_count", 32'(err_seen), 1);
      next_lat = 4;
      shots[2] = 1;
      drain("drain_after_timeout", 200);
      chk("after_timeout_err_count", 32'(err_seen), 1);

      // Done on the final counted cycle
      next_lat = TIMEOUT;
      shots[0] = 1;
      drain("drain_boundary", 200);
      chk("boundary_err_count", 32'(err_seen), 1);

      // Reset five cycles after ISSUE, late done afterwards
      gnt_log.delete();
      next_lat = 15;
      shots[2] = 1;
      wait_grants("wait_pre_reset", 1, 50);
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(12);
      gnt_log.delete();
      shots[1] = 1; shots[3] = 1;
      drain("drain_post_reset", 200);
      chk("post_reset_first", 32'(gnt_log[0]), 1);
      chk("post_reset_cnt", 32'(gnt_log.size()), 2);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         if (c % 50 == 0) begin
            for (int i = 0; i < NREQ; i++) prob[i] = int'($urandom_range(30));
         end
         next_lat = pick_lat();
         step(1);
      end
      for (int i = 0; i < NREQ; i++) prob[i] = 0;
      drain("drain_random", 4000);

      for (int i = 0; i < NREQ; i++) chk("no_drop", 32'(granted[i]), 32'(issued[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
